tag_alloc_ctrl: RTL and testbench
=================================

TAG_ALLOC_CTRL -- requirements
Module: tag_alloc_ctrl

Interface
REQ-001 SHALL have parameter NTAG, default 16, meaning number of ROB tags (0..NTAG-1); tag value 16 (6'b010000) is the invalid tag.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port issueValid  in  1  an instruction requests a tag.
REQ-005 SHALL have port issueDest  in  5  destination register; 0 means no destination.
REQ-006 SHALL have port issueReady  out  1  an issue is accepted this cycle when issueValid and issueReady are both high.
REQ-007 SHALL have port issueTag  out  6  the tag given at acceptance, equal to {2'b00, tail}.
REQ-008 SHALL have port commitValid  in  1  in-order retire of the head tag.
REQ-009 SHALL have port commitReady  out  1  a commit is accepted when commitValid and commitReady are both high.
REQ-010 SHALL have port writeEnable  out  1  write strobe to the register-status table, which is rising-edge sensitive.
REQ-011 SHALL have port writeIndex  out  5  register to write.
REQ-012 SHALL have port writedata  out  6  tag to store, or 16 to clear.
REQ-013 SHALL have port flush  in  1  discard all tags and clear the table.
REQ-014 SHALL have ports count (out, 5 bits), full (out, 1) and empty (out, 1) giving occupancy status.

Function
REQ-015 SHALL hold a circular tag queue: head and tail, 4 bits each, wrapping 15->0; a per-tag destination array (5 bits each); and a shadow status array of 32 x 6 bits.
REQ-016 SHALL implement the FSM states CLR, IDLE, WR and GAP.
REQ-017 SHALL, in CLR, write 16 to registers 1..31 in turn, one pulse per two cycles (WR high, then GAP low); after register 31 is written it SHALL go to IDLE.
REQ-018 SHALL assert issueReady only when the state is IDLE, full=0, commitValid=0 and flush=0.
REQ-019 SHALL assert commitReady only when the state is IDLE, empty=0 and flush=0; commit has priority over issue.
REQ-020 SHALL, on issue accept at edge N: set dest[tail]=issueDest, advance tail, and increment count.
REQ-021 SHALL, on the same issue accept with issueDest!=0: set shadow[issueDest]=tag, drive writeEnable=1 in cycle N+1 with writeIndex=issueDest and writedata=tag, drive writeEnable=0 in N+2 (GAP), and return to IDLE in N+3.
REQ-022 SHALL, on an issue accept with issueDest=0, perform no write and stay in IDLE; back-to-back accepts are legal in that case.
REQ-023 SHALL, on commit accept: advance head and decrement count.
REQ-024 SHALL, on a commit where d=dest[head], d!=0 and shadow[d]==head tag: set shadow[d]=16 and perform the WR/GAP write of 16 to d; otherwise it SHALL perform no write and stay in IDLE.
REQ-025 SHALL never raise writeEnable in two consecutive cycles; every pulse is exactly one cycle and is followed by at least one low cycle.
REQ-026 SHALL compute full = (count==16) and empty = (count==0); issue is blocked when full and commit is blocked when empty.
REQ-027 SHALL, when flush is sampled in IDLE, GAP or WR: finish any current pulse, then clear head, tail, count and all shadow entries to 16, and enter CLR.
REQ-028 SHALL ignore flush while in CLR.
REQ-029 SHALL keep writeIndex and writedata stable for the whole WR cycle.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, force: head=tail=count=0, shadow all 16, writeEnable=0, writeIndex=0, writedata=16, issueReady=0, commitReady=0, empty=1, full=0, state=CLR with sweep index 1.
REQ-031 SHALL, for rst asserted mid-WR, drop writeEnable at the next edge and abandon the pending write.
REQ-032 SHALL start the CLR sweep on the first cycle after rst deasserts; issueReady first rises 62 cycles after that.

Verification
REQ-033 SHALL verify: reset release -> 31 writeEnable pulses (index 1..31, data 16), then issueReady=1 with empty=1.
REQ-034 SHALL verify: issue dest=5 -> issueTag=0, one cycle later a pulse (index 5, data 0); issue dest=5 again -> tag=1, pulse (index 5, data 1); commit -> no write, because shadow[5]=1 and not 0.
REQ-035 SHALL verify: 16 issues with dest=0 -> full=1, issueReady=0, count=16; one commit -> full=0; the next issueTag=0 (wrap-around).
REQ-036 SHALL verify: commitValid and issueValid high together in IDLE -> commit accepted, issue stalled until IDLE returns.
REQ-037 SHALL verify: issue dest=7 tag 3, then commit of tag 3 -> pulse (index 7, data 16); no two adjacent writeEnable high cycles occur in any run.
REQ-038 SHALL verify: flush with count=5 -> count=0 and empty=1, then a 31-register clear sweep, then the next issueTag=0.

Source files
------------

// File: rtl/tag_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tag_alloc_ctrl
//
// Hands out ROB tags in order from a circular queue. The controller also keeps
// an external register-status table coherent through a single, edge-sensitive
// write strobe. It keeps a shadow copy of that table so a retiring tag can
// tell whether it is still the newest producer of its destination register.
// After reset or flush it sweeps the whole table back to the invalid tag.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rst          : synchronous active-high reset
//   issueValid   : an instruction requests a tag
//   issueDest    : destination register of that instruction (0 = none)
//   issueReady   : issue accepted this cycle when issueValid is also high
//   issueTag     : tag handed out at acceptance ({2'b00, tail})
//   commitValid  : in-order retire of the head tag
//   commitReady  : commit accepted this cycle when commitValid is also high
//   writeEnable  : one-cycle write strobe to the register-status table
//   writeIndex   : register being written
//   writedata    : tag to store, or the invalid tag to clear
//   flush        : discard all tags and clear the table
//   count        : number of tags currently outstanding
//   full / empty : occupancy status
// ---------------------------------------------------------------------------
module tag_alloc_ctrl #(
    parameter int NTAG = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issueValid,
    input  logic [4:0] issueDest,
    output logic       issueReady,
    output logic [5:0] issueTag,
    input  logic       commitValid,
    output logic       commitReady,
    output logic       writeEnable,
    output logic [4:0] writeIndex,
    output logic [5:0] writedata,
    input  logic       flush,
    output logic [4:0] count,
    output logic       full,
    output logic       empty
);

    localparam logic [5:0] INVALID_TAG = 6'(NTAG);
    localparam logic [4:0] FULL_COUNT  = 5'(NTAG);
    localparam logic [4:0] LAST_REG    = 5'd31;

    typedef enum logic [1:0] {CLR, IDLE, WR, GAP} state_t;

    state_t      state_q, state_d;
    logic [4:0]  sweep_q, sweep_d;
    logic [3:0]  head_q, head_d;
    logic [3:0]  tail_q, tail_d;
    logic [4:0]  count_q, count_d;
    logic [4:0]  dest_q [16];
    logic [4:0]  dest_d [16];
    logic [5:0]  shadow_q [32];
    logic [5:0]  shadow_d [32];
    logic        we_q, we_d;
    logic [4:0]  widx_q, widx_d;
    logic [5:0]  wdata_q, wdata_d;

    logic        issue_acc;
    logic        commit_acc;
    logic        commit_hit;
    logic        flush_taken;
    logic [4:0]  head_dest;

    assign count       = count_q;
    assign full        = (count_q == FULL_COUNT);
    assign empty       = (count_q == 5'd0);
    assign issueTag    = {2'b00, tail_q};
    assign writeEnable = we_q;
    assign writeIndex  = widx_q;
    assign writedata   = wdata_q;

    // Handshakes are only open in IDLE; a pending commit or flush always
    // beats a new issue.
    assign issueReady  = (state_q == IDLE) && !full && !commitValid && !flush;
    assign commitReady = (state_q == IDLE) && !empty && !flush;
    assign issue_acc   = issueValid && issueReady;
    assign commit_acc  = commitValid && commitReady;

    // A retiring tag may only clear its register if no younger instruction
    // has since claimed the same destination.
    assign head_dest   = dest_q[head_q];
    assign commit_hit  = (head_dest != 5'd0) && (shadow_q[head_dest] == {2'b00, head_q});

    // Flush is ignored while the clear sweep is already running.
    assign flush_taken = flush && (state_q != CLR);

    // State register together with all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR;
            sweep_q <= 5'd1;
            head_q  <= 4'd0;
            tail_q  <= 4'd0;
            count_q <= 5'd0;
            we_q    <= 1'b0;
            widx_q  <= 5'd0;
            wdata_q <= INVALID_TAG;
            for (int i = 0; i < 32; i++) shadow_q[i] <= INVALID_TAG;
            for (int i = 0; i < 16; i++) dest_q[i] <= 5'd0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            we_q     <= we_d;
            widx_q   <= widx_d;
            wdata_q  <= wdata_d;
            shadow_q <= shadow_d;
            dest_q   <= dest_d;
        end
    end

    // Next-state logic. In CLR the strobe flop itself provides the
    // high/low pacing, so the sweep index advances once per finished pulse.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            CLR: begin
                if (we_q) begin
                    if (sweep_q == LAST_REG) state_d = IDLE;
                    else                     sweep_d = sweep_q + 5'd1;
                end
            end
            IDLE: begin
                if (issue_acc && (issueDest != 5'd0)) state_d = WR;
                else if (commit_acc && commit_hit)    state_d = WR;
            end
            WR:      state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = CLR;
        endcase
        if (flush_taken) begin
            state_d = CLR;
            sweep_d = 5'd1;
        end
    end

    // Output and datapath logic. The strobe defaults low, which ends every
    // pulse after one cycle. Index and data hold their last value, so they
    // stay stable for the whole pulse.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        dest_d   = dest_q;
        shadow_d = shadow_q;
        we_d     = 1'b0;
        widx_d   = widx_q;
        wdata_d  = wdata_q;
        if (flush_taken) begin
            head_d  = 4'd0;
            tail_d  = 4'd0;
            count_d = 5'd0;
            for (int i = 0; i < 32; i++) shadow_d[i] = INVALID_TAG;
        end else begin
            unique case (state_q)
                CLR: begin
                    if (!we_q) begin
                        we_d    = 1'b1;
                        widx_d  = sweep_q;
                        wdata_d = INVALID_TAG;
                    end
                end
                IDLE: begin
                    if (commit_acc) begin
                        head_d  = head_q + 4'd1;
                        count_d = count_q - 5'd1;
                        if (commit_hit) begin
                            shadow_d[head_dest] = INVALID_TAG;
                            we_d    = 1'b1;
                            widx_d  = head_dest;
                            wdata_d = INVALID_TAG;
                        end
                    end else if (issue_acc) begin
                        dest_d[tail_q] = issueDest;
                        tail_d  = tail_q + 4'd1;
                        count_d = count_q + 5'd1;
                        if (issueDest != 5'd0) begin
                            shadow_d[issueDest] = issueTag;
                            we_d    = 1'b1;
                            widx_d  = issueDest;
                            wdata_d = issueTag;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tag_alloc_ctrl
//
// Self-checking bench for tag_alloc_ctrl. It exercises the clear sweeps,
// issue/commit sequences, ready-logic vectors, wrap-around, flush and reset
// during a write. It then runs a random issue/commit phase that is scored
// against a transaction-level model: a tag queue, a shadow table and the
// cycle numbers at which the next write and the next idle cycle are due.
// ---------------------------------------------------------------------------
module tb_tag_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       issueValid;
    logic [4:0] issueDest;
    logic       issueReady;
    logic [5:0] issueTag;
    logic       commitValid;
    logic       commitReady;
    logic       writeEnable;
    logic [4:0] writeIndex;
    logic [5:0] writedata;
    logic       flush;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int total = 0;
    int bad   = 0;

    tag_alloc_ctrl #(.NTAG(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .issueValid (issueValid),
        .issueDest  (issueDest),
        .issueReady (issueReady),
        .issueTag   (issueTag),
        .commitValid(commitValid),
        .commitReady(commitReady),
        .writeEnable(writeEnable),
        .writeIndex (writeIndex),
        .writedata  (writedata),
        .flush      (flush),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv;
        logic cv;
        logic fl;
        logic expIr;
        logic expCr;
    } vec_t;

    typedef struct {
        int tag;
        int dest;
    } ent_t;

    // Scores a single comparison.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    // Drives all inputs, then lets combinational outputs settle.
    task automatic applyStimulus(input logic iv, input logic cv, input logic [4:0] d, input logic fl);
        issueValid  = iv;
        commitValid = cv;
        issueDest   = d;
        flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The strobe must never be high on two consecutive cycles.
    logic prevWe = 1'b0;
    always @(negedge clk) begin
        checkOutput("we_adjacent", int'(writeEnable && prevWe), 0);
        prevWe = writeEnable;
    end

    // Called in the first cycle after reset release or after a flush edge.
    // Expects 31 clear pulses and issueReady exactly 62 cycles later.
    task automatic sweepCheck(input string name, input logic pokeFlush);
        int pulses  = 0;
        int expIdx  = 1;
        int readyAt = -1;
        for (int k = 1; k <= 80; k++) begin
            if (pokeFlush && k == 10) applyStimulus(0, 0, 5'd0, 1);
            else                      applyStimulus(0, 0, 5'd0, 0);
            tick();
            if (writeEnable) begin
                checkOutput({name, " idx"}, writeIndex, expIdx);
                checkOutput({name, " data"}, writedata, 16);
                expIdx++;
                pulses++;
            end
            if (issueReady) begin
                readyAt = k;
                break;
            end
        end
        applyStimulus(0, 0, 5'd0, 0);
        checkOutput({name, " pulses"}, pulses, 31);
        checkOutput({name, " ready cycle"}, readyAt, 62);
        checkOutput({name, " empty"}, empty, 1);
    endtask

    // One issue accept from IDLE. For a real destination the task also
    // follows the write pulse and the gap cycle.
    task automatic doIssue(input logic [4:0] d, input int expTag);
        applyStimulus(1, 0, d, 0);
        checkOutput("issue ready", issueReady, 1);
        checkOutput("issue tag", issueTag, expTag);
        tick();
        applyStimulus(0, 0, 5'd0, 0);
        if (d != 5'd0) begin
            checkOutput("issue we", writeEnable, 1);
            checkOutput("issue idx", writeIndex, d);
            checkOutput("issue data", writedata, expTag);
            tick();
            checkOutput("issue gap we", writeEnable, 0);
            checkOutput("issue gap ready", issueReady, 0);
            tick();
        end else begin
            checkOutput("issue no write", writeEnable, 0);
        end
    endtask

    // One commit accept from IDLE, with or without a clearing write.
    task automatic doCommit(input logic expWrite, input logic [4:0] d);
        applyStimulus(0, 1, 5'd0, 0);
        checkOutput("commit ready", commitReady, 1);
        checkOutput("commit blocks issue", issueReady, 0);
        tick();
        applyStimulus(0, 0, 5'd0, 0);
        checkOutput("commit we", writeEnable, expWrite);
        if (expWrite) begin
            checkOutput("commit idx", writeIndex, d);
            checkOutput("commit data", writedata, 16);
            tick();
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        ent_t q [$];
        int   shadow [32];
        int   nextTag;
        int   busyEnd;
        int   pulseAt;
        int   pIdx;
        int   pData;
        logic iv;
        logic cv;
        logic [4:0] d;
        logic eIr;
        logic eCr;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state, then the first clear sweep.
        rst = 1'b1;
        applyStimulus(0, 0, 5'd0, 0);
        repeat (3) tick();
        checkOutput("rst we", writeEnable, 0);
        checkOutput("rst idx", writeIndex, 0);
        checkOutput("rst data", writedata, 16);
        checkOutput("rst issueReady", issueReady, 0);
        checkOutput("rst commitReady", commitReady, 0);
        checkOutput("rst empty", empty, 1);
        checkOutput("rst full", full, 0);
        checkOutput("rst count", count, 0);
        rst = 1'b0;
        sweepCheck("reset sweep", 1'b1);
        checkOutput("post sweep tag", issueTag, 0);

        // Same register claimed twice; the older commit must not clear it.
        doIssue(5'd5, 0);
        doIssue(5'd5, 1);
        doCommit(1'b0, 5'd0);
        doCommit(1'b1, 5'd5);

        // Commit beats issue; the stalled issue goes through once IDLE returns.
        doIssue(5'd3, 2);
        applyStimulus(1, 1, 5'd7, 0);
        checkOutput("both commitReady", commitReady, 1);
        checkOutput("both issueReady", issueReady, 0);
        tick();
        applyStimulus(1, 0, 5'd7, 0);
        checkOutput("stall we", writeEnable, 1);
        checkOutput("stall idx", writeIndex, 3);
        checkOutput("stall data", writedata, 16);
        checkOutput("stall ready wr", issueReady, 0);
        tick();
        checkOutput("stall gap we", writeEnable, 0);
        checkOutput("stall ready gap", issueReady, 0);
        tick();
        checkOutput("stall ready idle", issueReady, 1);
        checkOutput("stall tag", issueTag, 3);
        tick();
        applyStimulus(0, 0, 5'd0, 0);
        checkOutput("late issue we", writeEnable, 1);
        checkOutput("late issue idx", writeIndex, 7);
        checkOutput("late issue data", writedata, 3);
        tick();
        tick();
        doCommit(1'b1, 5'd7);

        // Ready logic vectors with one tag outstanding; no clock edges.
        doIssue(5'd0, 4);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].cv, 5'd0, vecs[i].fl);
            checkOutput($sformatf("vec%0d issueReady", i), issueReady, vecs[i].expIr);
            checkOutput($sformatf("vec%0d commitReady", i), commitReady, vecs[i].expCr);
        end
        applyStimulus(0, 0, 5'd0, 0);
        checkOutput("vec count", count, 1);

        // Flush with five tags outstanding.
        for (int i = 0; i < 4; i++) doIssue(5'd0, 5 + i);
        checkOutput("pre flush count", count, 5);
        applyStimulus(0, 0, 5'd0, 1);
        checkOutput("flush issueReady", issueReady, 0);
        checkOutput("flush commitReady", commitReady, 0);
        tick();
        checkOutput("flush count", count, 0);
        checkOutput("flush empty", empty, 1);
        sweepCheck("flush sweep", 1'b0);
        checkOutput("flush tag", issueTag, 0);

        // Fill to 16 back-to-back, then wrap around.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 5'd0, 0);
            checkOutput("fill ready", issueReady, 1);
            checkOutput("fill tag", issueTag, i);
            tick();
        end
        applyStimulus(1, 0, 5'd0, 0);
        checkOutput("full flag", full, 1);
        checkOutput("full count", count, 16);
        checkOutput("full issueReady", issueReady, 0);
        tick();
        checkOutput("full hold count", count, 16);
        doCommit(1'b0, 5'd0);
        checkOutput("unfull flag", full, 0);
        checkOutput("unfull count", count, 15);
        checkOutput("wrap tag", issueTag, 0);

        // Reset during a write pulse abandons it.
        applyStimulus(1, 0, 5'd9, 0);
        tick();
        applyStimulus(0, 0, 5'd0, 0);
        checkOutput("midwr we", writeEnable, 1);
        rst = 1'b1;
        tick();
        checkOutput("midwr rst we", writeEnable, 0);
        checkOutput("midwr rst idx", writeIndex, 0);
        checkOutput("midwr rst data", writedata, 16);
        checkOutput("midwr rst count", count, 0);
        tick();
        rst = 1'b0;
        sweepCheck("reset2 sweep", 1'b0);

        // Random issue/commit traffic against the transaction model.
        for (int i = 0; i < 32; i++) shadow[i] = 16;
        nextTag = 0;
        busyEnd = 0;
        pulseAt = -1;
        pIdx    = 0;
        pData   = 0;
        for (int c = 0; c < 600; c++) begin
            iv = 1'($urandom_range(0, 1));
            cv = ($urandom_range(0, 3) == 0);
            d  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
            applyStimulus(iv, cv, d, 0);
            eIr = (c >= busyEnd) && (q.size() < 16) && !cv;
            eCr = (c >= busyEnd) && (q.size() > 0);
            checkOutput("rand issueReady", issueReady, eIr);
            checkOutput("rand commitReady", commitReady, eCr);
            checkOutput("rand count", count, q.size());
            checkOutput("rand full", full, int'(q.size() == 16));
            checkOutput("rand empty", empty, int'(q.size() == 0));
            checkOutput("rand tag", issueTag, nextTag);
            checkOutput("rand we", writeEnable, int'(c == pulseAt));
            if (c == pulseAt) begin
                checkOutput("rand idx", writeIndex, pIdx);
                checkOutput("rand data", writedata, pData);
            end
            if (eCr && cv) begin
                ent_t e;
                e = q.pop_front();
                if (e.dest != 0 && shadow[e.dest] == e.tag) begin
                    shadow[e.dest] = 16;
                    pulseAt = c + 1;
                    pIdx    = e.dest;
                    pData   = 16;
                    busyEnd = c + 3;
                end
            end else if (eIr && iv) begin
                q.push_back('{nextTag, int'(d)});
                if (d != 5'd0) begin
                    shadow[d] = nextTag;
                    pulseAt = c + 1;
                    pIdx    = d;
                    pData   = nextTag;
                    busyEnd = c + 3;
                end
                nextTag = (nextTag + 1) % 16;
            end
            tick();
        end
        applyStimulus(0, 0, 5'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
